// File: rtl/qbu_ts_pkg.sv
// Shared constants and types for the QBU TX timestamp path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: timestamp entry width helpers, capture slot struct, and PTP
// frame constants shared with qbu_tx_timestamp.
package qbu_ts_pkg;

  localparam int TS_SEQ_W       = 8;
  localparam int TS_DEF_TIME_W  = 64;
  localparam int TS_DEF_PORTS   = 4;

  // RAM entry layout is {port, seq, time}; width for the default build.
  localparam int TS_ENTRY_W = TS_DEF_TIME_W + TS_SEQ_W + $clog2(TS_DEF_PORTS);

  // Entry width for an arbitrary instance configuration.
  function automatic int ts_entry_w(input int time_w, input int num_ports);
    return time_w + TS_SEQ_W + $clog2(num_ports);
  endfunction

  // Per-port capture slot for the default time width.
  typedef struct packed {
    logic [TS_SEQ_W-1:0]      seq;
    logic [TS_DEF_TIME_W-1:0] tm;
  } ts_slot_t;

  // PTP frame identification shared with the per-port timestamp blocks.
  localparam logic [15:0] PTP_ETHERTYPE        = 16'h88F7;
  localparam logic [3:0]  PTP_MSG_SYNC         = 4'h0;
  localparam logic [3:0]  PTP_MSG_DELAY_REQ    = 4'h1;
  localparam logic [3:0]  PTP_MSG_PDELAY_REQ   = 4'h2;
  localparam logic [3:0]  PTP_MSG_PDELAY_RESP  = 4'h3;

endpackage

// File: rtl/qbu_ts_rr_arb.sv
// Round-robin arbiter over the pending timestamp ports.
// Latency: grant is combinational from i_req/i_en; pointer updates on grant edge.
// Backpressure: i_en low suppresses any grant and freezes the pointer.
// Ports: i_clk/i_rst, i_req[NUM_PORTS], i_en -> o_gnt_vld, o_gnt_oh, o_gnt_idx.
module qbu_ts_rr_arb #(
  parameter int NUM_PORTS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic                         i_en,
  output logic                         o_gnt_vld,
  output logic [NUM_PORTS-1:0]         o_gnt_oh,
  output logic [$clog2(NUM_PORTS)-1:0] o_gnt_idx
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0] idx;

  // Scan from the pointer upward, wrapping at NUM_PORTS (which need not be a power of 2).
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PORT_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (i_en && !o_gnt_vld && i_req[idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = idx;
      end
    end
    o_gnt_oh = '0;
    if (o_gnt_vld) o_gnt_oh[o_gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (o_gnt_vld)
      rr_ptr_d = (o_gnt_idx == PORT_W'(NUM_PORTS-1)) ? '0 : o_gnt_idx + PORT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/qbu_tx_ts_ram_ctrl.sv
// Shared TX PTP timestamp RAM controller: per-port capture, RR arbitration, circular RAM.
// Latency: irq in cycle 0 -> registered RAM write in cycle 2 when uncontended.
// Backpressure: with DEPTH entries stored no grant is made; captured requests wait in their slots.
// Ports: i_ptp_time, i_mac_time_irq/i_mac_frame_seq (per port) in; o_ram_wr_* to RAM;
//        o_ts_rd_addr/o_ts_count/o_ts_irq and i_ts_rd_done on the CPU readout side.
// Option: define QBU_TS_DROP_CNT_EN to add o_ts_drop_cnt (saturating count of dropped requests).
module qbu_tx_ts_ram_ctrl
  import qbu_ts_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int TIME_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic [TIME_WIDTH-1:0]                      i_ptp_time,
  input  logic [NUM_PORTS-1:0]                       i_mac_time_irq,
  input  logic [8*NUM_PORTS-1:0]                     i_mac_frame_seq,
  output logic                                       o_ram_wr_en,
  output logic [$clog2(DEPTH)-1:0]                   o_ram_wr_addr,
  output logic [ts_entry_w(TIME_WIDTH,NUM_PORTS)-1:0] o_ram_wr_data,
  output logic [$clog2(DEPTH)-1:0]                   o_ts_rd_addr,
  input  logic                                       i_ts_rd_done,
  output logic [$clog2(DEPTH):0]                     o_ts_count,
  output logic                                       o_ts_irq
`ifdef QBU_TS_DROP_CNT_EN
  ,output logic [15:0]                               o_ts_drop_cnt
`endif
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PORT_W  = $clog2(NUM_PORTS);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int ENTRY_W = ts_entry_w(TIME_WIDTH, NUM_PORTS);

  typedef struct packed {
    logic [TS_SEQ_W-1:0]   seq;
    logic [TIME_WIDTH-1:0] tm;
  } slot_t;

  slot_t [NUM_PORTS-1:0] slot_q, slot_d;
  logic  [NUM_PORTS-1:0] pend_q, pend_d;
  logic  [ADDR_W-1:0]    head_q, head_d;
  logic  [ADDR_W-1:0]    tail_q, tail_d;
  logic  [CNT_W-1:0]     count_q, count_d;
  logic                  wr_en_q, wr_en_d;
  logic  [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic  [ENTRY_W-1:0]   wr_data_q, wr_data_d;

  logic                  gnt_vld;
  logic  [NUM_PORTS-1:0] gnt_oh;
  logic  [PORT_W-1:0]    gnt_idx;
  logic                  pop;

  qbu_ts_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (pend_q),
    .i_en      (count_q < CNT_W'(DEPTH)),
    .o_gnt_vld (gnt_vld),
    .o_gnt_oh  (gnt_oh),
    .o_gnt_idx (gnt_idx)
  );

`ifdef QBU_TS_DROP_CNT_EN
  logic [NUM_PORTS-1:0] drop;
  logic [PORT_W:0]      n_drop;
  logic [16:0]          drop_sum;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
`endif

  // Capture: a port may reload its slot when idle, or in the very cycle its
  // old entry is being granted (old value goes to RAM, new one stays pending).
  always_comb begin
    pend_d = pend_q;
    slot_d = slot_q;
`ifdef QBU_TS_DROP_CNT_EN
    drop   = '0;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_oh[p]) pend_d[p] = 1'b0;
      if (i_mac_time_irq[p]) begin
        if (!pend_q[p] || gnt_oh[p]) begin
          slot_d[p].seq = i_mac_frame_seq[8*p +: 8];
          slot_d[p].tm  = i_ptp_time;
          pend_d[p]     = 1'b1;
        end
`ifdef QBU_TS_DROP_CNT_EN
        else begin
          drop[p] = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    pop       = i_ts_rd_done && (count_q != '0);
    head_d    = pop     ? head_q + ADDR_W'(1) : head_q;
    tail_d    = gnt_vld ? tail_q + ADDR_W'(1) : tail_q;
    count_d   = count_q + CNT_W'(gnt_vld) - CNT_W'(pop);
    wr_en_d   = gnt_vld;
    wr_addr_d = gnt_vld ? tail_q : wr_addr_q;
    wr_data_d = gnt_vld ? {gnt_idx, slot_q[gnt_idx]} : wr_data_q;
  end

`ifdef QBU_TS_DROP_CNT_EN
  always_comb begin
    n_drop = '0;
    for (int p = 0; p < NUM_PORTS; p++) n_drop = n_drop + (PORT_W+1)'(drop[p]);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign o_ts_drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q    <= '0;
      pend_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      slot_q    <= slot_d;
      pend_q    <= pend_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_ram_wr_en   = wr_en_q;
  assign o_ram_wr_addr = wr_addr_q;
  assign o_ram_wr_data = wr_data_q;
  assign o_ts_rd_addr  = head_q;
  assign o_ts_count    = count_q;
  assign o_ts_irq      = (count_q != '0);

endmodule
